gate_response_checker: RTL and testbench

//  On-chip response checker for 2-input logic-gate designs such as the IPI AndLogic wrapper.

---
 rtl/gate_response_checker.sv | 154 +++++++++++++++
 tb/tb_gate_response_checker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Stimulus/response checker for a 2-input gate-under-test: drives (a,b), samples dut_y after a settle delay.
// Optional first-failure log enabled by defining GATE_CHK_FAIL_LOG_EN.
module gate_response_checker #(
  parameter int SETTLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [1:0]       gate_op,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_a,
  input  logic             vec_b,
  output logic             drv_a,
  output logic             drv_b,
  input  logic             dut_y,
  output logic             res_valid,
  output logic             res_pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef GATE_CHK_FAIL_LOG_EN
  ,
  output logic             fail_seen,
  output logic [CNT_W-1:0] fail_idx,
  output logic             fail_a,
  output logic             fail_b,
  output logic             fail_y
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_t     state, state_nxt;
  logic [7:0] settle_cnt;
  logic [1:0] op_q;
  logic       accept;
  logic       check_done;
  logic       pass;

  function automatic logic gate_f(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pass = (dut_y == gate_f(op_q, drv_a, drv_b));

  always_comb begin
    state_nxt  = state;
    vec_ready  = 1'b0;
    accept     = 1'b0;
    check_done = 1'b0;
    case (state)
      IDLE: begin
        vec_ready = 1'b1;
        if (vec_valid && !clr) begin
          accept    = 1'b1;
          state_nxt = (SETTLE_CYC == 0) ? CHECK : SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = CHECK;
      end
      CHECK: begin
        check_done = !clr;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               settle_cnt <= 8'd0;
    else if (accept)          settle_cnt <= 8'd0;
    else if (state == SETTLE) settle_cnt <= settle_cnt + 8'd1;
  end

  // Accept stage: vector and expected function are frozen for the whole check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_a <= 1'b0;
      drv_b <= 1'b0;
      op_q  <= 2'b00;
    end else if (accept) begin
      drv_a <= vec_a;
      drv_b <= vec_b;
      op_q  <= gate_op;
    end
  end

  // Result stage: sample dut_y on the edge leaving CHECK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
    end else if (clr) begin
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      vec_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      res_valid <= check_done;
      if (check_done) begin
        res_pass <= pass;
        vec_cnt  <= sat_inc(vec_cnt);
        if (!pass) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

`ifdef GATE_CHK_FAIL_LOG_EN
  // Only the first mismatch since reset/clr is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_a    <= 1'b0;
      fail_b    <= 1'b0;
      fail_y    <= 1'b0;
    end else if (clr) begin
      fail_seen <= 1'b0;
      fail_idx  <= '0;
      fail_a    <= 1'b0;
      fail_b    <= 1'b0;
      fail_y    <= 1'b0;
    end else if (check_done && !pass && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_idx  <= vec_cnt;
      fail_a    <= drv_a;
      fail_b    <= drv_b;
      fail_y    <= dut_y;
    end
  end
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (SETTLE_CYC=3/CNT_W=8 and SETTLE_CYC=0/CNT_W=4)
// checked every cycle against a transaction-level model, plus literal end-of-test expectations.
module tb_gate_response_checker;

  localparam int S   [2] = '{3, 0};
  localparam int MAXC[2] = '{255, 15};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr [2];
  logic       vld [2];
  logic       va  [2];
  logic       vb  [2];
  logic [1:0] op  [2];
  logic       rdy [2];
  logic       da  [2];
  logic       db  [2];
  logic       y   [2];
  logic       rv  [2];
  logic       rp  [2];
  logic [7:0] vc  [2];
  logic [7:0] ec  [2];
  logic [3:0] vc1, ec1;
  int         fm  [2];
`ifdef GATE_CHK_FAIL_LOG_EN
  logic       fs [2];
  logic [7:0] fi [2];
  logic       fa [2];
  logic       fb [2];
  logic       fy [2];
  logic [3:0] fi1;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int rv_cnt [2];
  bit hist [$];

  // model state
  int       m_rem [2];
  bit       m_a [2], m_b [2], m_rv [2], m_rp [2];
  bit [1:0] m_op [2];
  int       m_vec [2], m_err [2];
  bit       m_fs [2], m_fa [2], m_fb [2], m_fy [2];
  int       m_fi [2];
  bit       yv, ok;

  always #5 clk = ~clk;

  function automatic logic dut_fn(input int mode, input logic a, input logic b);
    case (mode)
      0:       return a & b;
      1:       return 1'b1;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic bit spec_gate(input bit [1:0] o, input bit a, input bit b);
    case (o)
      2'd0:    return a && b;
      2'd1:    return a || b;
      2'd2:    return a != b;
      default: return !(a && b);
    endcase
  endfunction

  assign y[0] = dut_fn(fm[0], da[0], db[0]);
  assign y[1] = dut_fn(fm[1], da[1], db[1]);
  assign vc[1] = {4'b0, vc1};
  assign ec[1] = {4'b0, ec1};
`ifdef GATE_CHK_FAIL_LOG_EN
  assign fi[1] = {4'b0, fi1};
`endif

  gate_response_checker #(.SETTLE_CYC(3), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .gate_op(op[0]), .vec_valid(vld[0]),
    .vec_ready(rdy[0]), .vec_a(va[0]), .vec_b(vb[0]), .drv_a(da[0]), .drv_b(db[0]),
    .dut_y(y[0]), .res_valid(rv[0]), .res_pass(rp[0]), .vec_cnt(vc[0]), .err_cnt(ec[0])
`ifdef GATE_CHK_FAIL_LOG_EN
    , .fail_seen(fs[0]), .fail_idx(fi[0]), .fail_a(fa[0]), .fail_b(fb[0]), .fail_y(fy[0])
`endif
  );

  gate_response_checker #(.SETTLE_CYC(0), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .gate_op(op[1]), .vec_valid(vld[1]),
    .vec_ready(rdy[1]), .vec_a(va[1]), .vec_b(vb[1]), .drv_a(da[1]), .drv_b(db[1]),
    .dut_y(y[1]), .res_valid(rv[1]), .res_pass(rp[1]), .vec_cnt(vc1), .err_cnt(ec1)
`ifdef GATE_CHK_FAIL_LOG_EN
    , .fail_seen(fs[1]), .fail_idx(fi1), .fail_a(fa[1]), .fail_b(fb[1]), .fail_y(fy[1])
`endif
  );

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d, required %0d", name, d, $time, act, exp);
    end
  endtask

  // Transaction model: an accepted vector yields its result S+1 edges later
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_rv[d] = 1'b0;
      if (!rst_n || clr[d]) begin
        m_rem[d] = 0; m_vec[d] = 0; m_err[d] = 0; m_rp[d] = 1'b0;
        m_fs[d] = 1'b0; m_fi[d] = 0; m_fa[d] = 1'b0; m_fb[d] = 1'b0; m_fy[d] = 1'b0;
        if (!rst_n) begin
          m_a[d] = 1'b0; m_b[d] = 1'b0; m_op[d] = 2'd0;
        end
      end else if (m_rem[d] > 0) begin
        m_rem[d]--;
        if (m_rem[d] == 0) begin
          yv = dut_fn(fm[d], m_a[d], m_b[d]);
          ok = (yv == spec_gate(m_op[d], m_a[d], m_b[d]));
          m_rv[d] = 1'b1;
          m_rp[d] = ok;
          if (!ok && !m_fs[d]) begin
            m_fs[d] = 1'b1; m_fi[d] = m_vec[d]; m_fa[d] = m_a[d]; m_fb[d] = m_b[d]; m_fy[d] = yv;
          end
          if (m_vec[d] < MAXC[d]) m_vec[d]++;
          if (!ok && m_err[d] < MAXC[d]) m_err[d]++;
        end
      end else if (vld[d]) begin
        m_a[d] = va[d]; m_b[d] = vb[d]; m_op[d] = op[d];
        m_rem[d] = S[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("vec_ready", d, 32'(rdy[d]), 32'(m_rem[d] == 0));
      check("drv_a", d, 32'(da[d]), 32'(m_a[d]));
      check("drv_b", d, 32'(db[d]), 32'(m_b[d]));
      check("res_valid", d, 32'(rv[d]), 32'(m_rv[d]));
      check("res_pass", d, 32'(rp[d]), 32'(m_rp[d]));
      check("vec_cnt", d, 32'(vc[d]), 32'(m_vec[d]));
      check("err_cnt", d, 32'(ec[d]), 32'(m_err[d]));
`ifdef GATE_CHK_FAIL_LOG_EN
      check("fail_seen", d, 32'(fs[d]), 32'(m_fs[d]));
      check("fail_idx", d, 32'(fi[d]), 32'(m_fi[d]));
      check("fail_abY", d, {29'd0, fa[d], fb[d], fy[d]}, {29'd0, m_fa[d], m_fb[d], m_fy[d]});
`endif
      if (rv[d] === 1'b1) rv_cnt[d]++;
    end
    if (rv[0] === 1'b1) hist.push_back(rp[0]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (rdy[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("ready_timeout", d, 32'(n < 50), 32'd1);
  endtask

  task automatic send(input int d, input bit a, input bit b, input bit [1:0] o);
    va[d] = a; vb[d] = b; op[d] = o; vld[d] = 1'b1;
    wait_ready(d);
    tick();
    vld[d] = 1'b0;
    op[d] = ~o;
  endtask

  task automatic do_clr(input int d);
    clr[d] = 1'b1;
    tick();
    clr[d] = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] hist_bits();
    logic [31:0] h = 0;
    foreach (hist[i]) h = {h[30:0], 1'(hist[i])};
    return h;
  endfunction

  bit [1:0] vecs [6] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10};
  int c0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; vld[d] = 1'b0; va[d] = 1'b0; vb[d] = 1'b0; op[d] = 2'd0; fm[d] = 0; rv_cnt[d] = 0;
    end
    repeat (3) tick();
    check("reset_ready", 0, 32'(rdy[0]), 32'd1);
    check("reset_vec_cnt", 0, 32'(vc[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: correct AND DUT
    hist.delete();
    foreach (vecs[i]) send(0, vecs[i][1], vecs[i][0], 2'd0);
    wait_ready(0);
    tick();
    check("t1_vec_cnt", 0, 32'(vc[0]), 32'd6);
    check("t1_err_cnt", 0, 32'(ec[0]), 32'd0);
    check("t1_npulse", 0, 32'(hist.size()), 32'd6);
    check("t1_pass_seq", 0, hist_bits(), 32'b111111);
    do_clr(0);

    // 2: stuck-at-1 DUT
    fm[0] = 1;
    hist.delete();
    foreach (vecs[i]) send(0, vecs[i][1], vecs[i][0], 2'd0);
    wait_ready(0);
    tick();
    check("t2_pass_seq", 0, hist_bits(), 32'b010010);
    check("t2_err_cnt", 0, 32'(ec[0]), 32'd4);
    check("t2_model_err", 0, 32'(m_err[0]), 32'd4);
`ifdef GATE_CHK_FAIL_LOG_EN
    check("t2_fail_idx", 0, 32'(fi[0]), 32'd0);
    check("t2_fail_y", 0, {29'd0, fa[0], fb[0], fy[0]}, 32'b001);
`endif
    do_clr(0);

    // other expected functions against an AND DUT: OR 2, XOR 3, NAND 4 mismatches
    fm[0] = 0;
    for (int o = 1; o < 4; o++)
      for (int v = 0; v < 4; v++) send(0, bit'(v >> 1), bit'(v & 1), 2'(o));
    wait_ready(0);
    tick();
    check("ops_vec_cnt", 0, 32'(vc[0]), 32'd12);
    check("ops_err_cnt", 0, 32'(ec[0]), 32'd9);

    // 3: SETTLE_CYC=0, vec_valid held high
    c0 = rv_cnt[1];
    va[1] = 1'b1; vb[1] = 1'b1; op[1] = 2'd0; vld[1] = 1'b1;
    repeat (20) tick();
    vld[1] = 1'b0;
    check("t3_pulses", 1, 32'(rv_cnt[1] - c0), 32'd10);
    wait_ready(1);
    tick();
    do_clr(1);

    // 4: CNT_W=4 saturation with an always-wrong DUT
    fm[1] = 2;
    for (int i = 0; i < 20; i++) send(1, bit'(i >> 1), bit'(i & 1), 2'd0);
    wait_ready(1);
    tick();
    check("t4_vec_cnt", 1, 32'(vc[1]), 32'd15);
    check("t4_err_cnt", 1, 32'(ec[1]), 32'd15);

    // 5: reset during SETTLE
    c0 = rv_cnt[0];
    send(0, 1'b1, 1'b1, 2'd0);
    rst_n = 1'b0;
    tick();
    check("t5_ready_in_reset", 0, 32'(rdy[0]), 32'd1);
    check("t5_cnt_in_reset", 0, 32'(vc[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("t5_no_result", 0, 32'(rv_cnt[0] - c0), 32'd0);
    send(0, 1'b0, 1'b1, 2'd1);
    wait_ready(0);
    tick();
    check("t5_next_vec", 0, 32'(vc[0]), 32'd1);

    // 6: clr beats a simultaneous handshake
    va[0] = 1'b1; vb[0] = 1'b0; op[0] = 2'd2;
    clr[0] = 1'b1; vld[0] = 1'b1;
    tick();
    check("t6_not_accepted", 0, 32'(rdy[0]), 32'd1);
    check("t6_cnt_clr", 0, 32'(vc[0]), 32'd0);
    clr[0] = 1'b0;
    tick();
    check("t6_accepted", 0, 32'(rdy[0]), 32'd0);
    vld[0] = 1'b0;
    wait_ready(0);
    tick();
    check("t6_vec_cnt", 0, 32'(vc[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

endmodule
